// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the fetch/decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;
endpackage
`default_nettype wire

// File: rtl/ifq_storage.sv
`default_nettype none
// ============================================================================
// Module      : ifq_storage
// Description : DEPTH-entry register array, one write port, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_storage
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  if_entry_t     wdata,
    input  logic [PW-1:0] raddr,
    output if_entry_t     rdata
);
    // Data only; control state lives in the queue, so no reset here.
    if_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode instruction queue with flush; optional
//               zero-latency bypass when built with IFQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    if_entry_t w_wdata;
    if_entry_t w_head;
    logic      w_stored_valid;
    logic      w_bypass;
    logic      w_push;
    logic      w_pop;

    assign w_wdata        = '{pc: in_pc, instr: in_instr};
    assign w_stored_valid = (r_count != '0);

`ifdef IFQ_BYPASS_EN
    // An empty queue hands the incoming entry straight to decode without storing it.
    assign w_bypass = w_stored_valid ? 1'b0 : (in_valid & out_ready & ~flush);
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = w_stored_valid | w_bypass;
    assign w_push    = in_valid & in_ready & ~flush & ~w_bypass;
    assign w_pop     = w_stored_valid & out_ready & ~flush;
    assign count     = r_count;

    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (w_bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (w_stored_valid) begin
            out_pc    = w_head.pc;
            out_instr = w_head.instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );
endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Scoreboard bench for if_id_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;
    import if_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [2:0]      count;

    int n_tests = 0;
    int n_fail  = 0;

    if_entry_t sb_q [$];

    if_id_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return (pc * 32'd3) ^ 32'hA5C0_0000;
    endfunction

    // One clock of stimulus: check outputs against the scoreboard, then advance it.
    task automatic step(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        logic      byp;
        logic      m_push;
        logic      m_pop;
        int        n;
        if_entry_t e;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        out_ready = ordy;
        flush     = fl;
        #1;
        n   = sb_q.size();
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (n == 0) && iv && ordy && !fl;
`endif
        check("count", 64'(count), 64'(n));
        check("in_ready", 64'(in_ready), 64'(n != DEPTH));
        check("out_valid", 64'(out_valid), 64'((n != 0) || byp));
        if (byp) begin
            check("byp_pc", 64'(out_pc), 64'(pc));
            check("byp_instr", 64'(out_instr), 64'(mk_instr(pc)));
        end else if (n != 0) begin
            check("head_pc", 64'(out_pc), 64'(sb_q[0].pc));
            check("head_instr", 64'(out_instr), 64'(sb_q[0].instr));
        end else begin
            check("idle_pc", 64'(out_pc), 64'd0);
            check("idle_instr", 64'(out_instr), 64'(c_NOP));
        end
        m_pop  = (n != 0) && ordy && !fl;
        m_push = iv && (n != DEPTH) && !fl && !byp;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (m_pop) void'(sb_q.pop_front());
            if (m_push) begin
                e.pc    = pc;
                e.instr = mk_instr(pc);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pc;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle after reset
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill to full, then attempt a fifth push
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 32'h10, 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        step(1'b1, 32'h10, 1'b1, 1'b0);

        // Drain (0x10 not accepted on the full-pop cycle either)
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("drained_count", 64'(count), 64'd0);

        // Steady push+pop at count 2, wrapping the pointers
        pc = 32'h100;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, pc, 1'b0, 1'b0);
            pc += 4;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pc, 1'b1, 1'b0);
            pc += 4;
        end
        check("steady_count", 64'(count), 64'd2);

        // Grow to 3, then flush with a push in the same cycle
        step(1'b1, pc, 1'b0, 1'b0);
        pc += 4;
        step(1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Async reset mid-stream at count 2
        step(1'b1, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'(c_NOP));
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Empty queue with both sides active (bypass case when enabled)
        step(1'b1, 32'h400, 1'b1, 1'b0);
        step(1'b1, 32'h404, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
